// File: rtl/accum_adder_tree.sv
// accum_adder_tree: pipelined multi-beat product accumulator with rounding, saturation and valid/ready handshakes
module accum_adder_tree #(
  parameter int Bit_width  = 8,
  parameter int Num_inputs = 5,
  parameter int Max_beats  = 4
) (
  input  logic                            Clk,
  input  logic                            Reset_n,
  input  logic                            Enable,
  input  logic                            In_valid,
  output logic                            In_ready,
  input  logic                            In_last,
  input  logic [Num_inputs*2*Bit_width-1:0] Mul_results,
  input  logic                            Round_enable,
  input  logic                            Sat_enable,
  output logic                            Out_valid,
  input  logic                            Out_ready,
  output logic [Bit_width-1:0]            Digital_sum,
  output logic                            Overflow,
  output logic                            Group_error
);
  localparam int W2 = 2 * Bit_width;
  localparam int SW = W2 + $clog2(Num_inputs);
  localparam int AW = SW + $clog2(Max_beats) + 1;
  localparam int HW = AW - Bit_width;
  localparam int CW = Max_beats > 1 ? $clog2(Max_beats) : 1;
  localparam bit MULTI = Max_beats > 1;
  localparam logic [AW-1:0] HALF = AW'(1) << (Bit_width - 1);
  logic advance, load, at_max, last_beat;
  logic [SW-1:0] beat_sum, s1_sum;
  logic s1_valid, s1_last, s1_err;
  logic [CW-1:0] beat_cnt;
  logic [AW-1:0] acc, t;
  logic [HW-1:0] t_hi;
  always_comb begin
    beat_sum = '0;
    for (int k = 0; k < Num_inputs; k++) beat_sum = beat_sum + SW'(Mul_results[k*W2 +: W2]);
  end
  assign advance   = Enable && (!Out_valid || Out_ready);
  assign In_ready  = advance;
  assign at_max    = beat_cnt == CW'(Max_beats - 1);
  assign last_beat = In_last || at_max;
  assign load      = advance && s1_valid && s1_last;
  assign t         = acc + AW'(s1_sum) + (Round_enable ? HALF : '0);
  // only bits at or above the output scale matter downstream
  assign t_hi      = HW'(t >> Bit_width);
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s1_sum      <= '0;
      s1_valid    <= 1'b0;
      s1_last     <= 1'b0;
      s1_err      <= 1'b0;
      beat_cnt    <= '0;
      acc         <= '0;
      Out_valid   <= 1'b0;
      Digital_sum <= '0;
      Overflow    <= 1'b0;
      Group_error <= 1'b0;
    end else begin
      if (advance) begin
        s1_sum   <= beat_sum;
        s1_valid <= In_valid;
        s1_last  <= last_beat;
        s1_err   <= MULTI && !In_last && at_max;
        if (In_valid) beat_cnt <= last_beat ? '0 : beat_cnt + CW'(1);
      end
      if (advance && s1_valid) acc <= s1_last ? '0 : acc + AW'(s1_sum);
      if (load) begin
        Out_valid   <= 1'b1;
        Overflow    <= |t_hi[HW-1:Bit_width];
        Digital_sum <= (Sat_enable && |t_hi[HW-1:Bit_width]) ? '1 : t_hi[Bit_width-1:0];
        Group_error <= s1_err;
      end else if (Out_ready) begin
        Out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_accum_adder_tree.sv
// tb_accum_adder_tree: directed self-checking bench for accum_adder_tree (W=8, N=5, Max_beats=4)
module tb_accum_adder_tree;
  logic        Clk = 1'b0;
  logic        Reset_n, Enable, In_valid, In_ready, In_last;
  logic [79:0] Mul_results;
  logic        Round_enable, Sat_enable, Out_valid, Out_ready;
  logic [7:0]  Digital_sum;
  logic        Overflow, Group_error;
  int compared = 0;
  int mismatched = 0;

  accum_adder_tree #(.Bit_width(8), .Num_inputs(5), .Max_beats(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Enable(Enable), .In_valid(In_valid), .In_ready(In_ready),
    .In_last(In_last), .Mul_results(Mul_results), .Round_enable(Round_enable),
    .Sat_enable(Sat_enable), .Out_valid(Out_valid), .Out_ready(Out_ready),
    .Digital_sum(Digital_sum), .Overflow(Overflow), .Group_error(Group_error)
  );

  always #5 Clk = ~Clk;

  function automatic logic [79:0] pk(input logic [15:0] a, b, c, d, e);
    return {e, d, c, b, a};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // presents one beat for exactly one rising edge; consecutive calls are back-to-back
  task automatic beat(input logic [79:0] m, input logic last);
    Mul_results = m;
    In_last = last;
    In_valid = 1'b1;
    tick();
    In_valid = 1'b0;
    In_last = 1'b0;
  endtask

  task automatic out_chk(input string tag, input logic [7:0] ds, input logic ovf, input logic gerr);
    chk({tag, "_valid"}, 16'(Out_valid), 16'd1);
    chk({tag, "_sum"}, 16'(Digital_sum), 16'(ds));
    chk({tag, "_ovf"}, 16'(Overflow), 16'(ovf));
    chk({tag, "_gerr"}, 16'(Group_error), 16'(gerr));
  endtask

  initial begin
    Reset_n = 1'b0; Enable = 1'b1; In_valid = 1'b0; In_last = 1'b0; Mul_results = '0;
    Round_enable = 1'b0; Sat_enable = 1'b0; Out_ready = 1'b1;
    tick(); tick();
    chk("rst_valid", 16'(Out_valid), 16'd0);
    chk("rst_sum", 16'(Digital_sum), 16'd0);
    chk("rst_ovf", 16'(Overflow), 16'd0);
    chk("rst_gerr", 16'(Group_error), 16'd0);
    Reset_n = 1'b1;
    tick();
    chk("rst_ready", 16'(In_ready), 16'd1);

    beat(pk(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500), 1'b1);
    chk("basic_lat1", 16'(Out_valid), 16'd0);
    tick();
    out_chk("basic", 8'h0F, 1'b0, 1'b0);
    tick();
    chk("basic_drain", 16'(Out_valid), 16'd0);

    beat(pk(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000), 1'b1);
    tick();
    out_chk("ovf_nosat", 8'h80, 1'b1, 1'b0);
    Sat_enable = 1'b1;
    beat(pk(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000), 1'b1);
    tick();
    out_chk("ovf_sat", 8'hFF, 1'b1, 1'b0);
    Sat_enable = 1'b0;

    Round_enable = 1'b1;
    beat(pk(16'h0180, 0, 0, 0, 0), 1'b1);
    tick();
    out_chk("round_on", 8'h02, 1'b0, 1'b0);
    Round_enable = 1'b0;
    beat(pk(16'h0180, 0, 0, 0, 0), 1'b1);
    tick();
    out_chk("round_off", 8'h01, 1'b0, 1'b0);
    tick();

    beat(pk(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100), 1'b0);
    chk("multi_b1", 16'(Out_valid), 16'd0);
    beat(pk(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100), 1'b0);
    chk("multi_b2", 16'(Out_valid), 16'd0);
    beat(pk(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100), 1'b1);
    chk("multi_b3", 16'(Out_valid), 16'd0);
    tick();
    out_chk("multi", 8'h0F, 1'b0, 1'b0);
    tick();
    chk("multi_once", 16'(Out_valid), 16'd0);

    beat(pk(16'h0100, 0, 0, 0, 0), 1'b1);
    chk("b2b_a_lat", 16'(Out_valid), 16'd0);
    beat(pk(16'h0200, 0, 0, 0, 0), 1'b1);
    out_chk("b2b_a", 8'h01, 1'b0, 1'b0);
    chk("b2b_ready_a", 16'(In_ready), 16'd1);
    beat(pk(16'h0300, 0, 0, 0, 0), 1'b1);
    out_chk("b2b_b", 8'h02, 1'b0, 1'b0);
    chk("b2b_ready_b", 16'(In_ready), 16'd1);
    tick();
    out_chk("b2b_c", 8'h03, 1'b0, 1'b0);
    tick();
    chk("b2b_drain", 16'(Out_valid), 16'd0);

    for (int i = 0; i < 4; i++) begin
      beat(pk(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100), 1'b0);
      chk("force_pending", 16'(Out_valid), 16'd0);
    end
    beat(pk(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100), 1'b0);
    out_chk("force", 8'h14, 1'b0, 1'b1);
    beat(pk(16'h0100, 0, 0, 0, 0), 1'b1);
    chk("force_newgrp_pending", 16'(Out_valid), 16'd0);
    tick();
    out_chk("force_newgrp", 8'h06, 1'b0, 1'b0);
    tick();

    Out_ready = 1'b0;
    beat(pk(16'h0200, 0, 0, 0, 0), 1'b1);
    tick();
    out_chk("bp_load", 8'h02, 1'b0, 1'b0);
    Mul_results = pk(16'h0300, 0, 0, 0, 0);
    In_last = 1'b1;
    In_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_ready", 16'(In_ready), 16'd0);
      tick();
      out_chk("bp_hold", 8'h02, 1'b0, 1'b0);
    end
    Out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 16'(In_ready), 16'd1);
    tick();
    In_valid = 1'b0;
    In_last = 1'b0;
    chk("bp_drained", 16'(Out_valid), 16'd0);
    tick();
    out_chk("bp_next", 8'h03, 1'b0, 1'b0);
    tick();

    beat(pk(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100), 1'b0);
    beat(pk(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100), 1'b0);
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    chk("midrst_valid", 16'(Out_valid), 16'd0);
    beat(pk(16'h0400, 0, 0, 0, 0), 1'b1);
    chk("midrst_pending", 16'(Out_valid), 16'd0);
    tick();
    out_chk("midrst", 8'h04, 1'b0, 1'b0);
    tick();

    Enable = 1'b0;
    #1;
    chk("enable_low_ready", 16'(In_ready), 16'd0);
    Enable = 1'b1;
    #1;
    chk("enable_high_ready", 16'(In_ready), 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
